// File: rtl/vp_pkg.sv
// Shared types for the value-prediction validation queue.
package vp_pkg;

  typedef logic [31:1] pc_t;
  typedef logic [31:0] value_t;

  typedef struct packed {
    pc_t    pc;
    value_t result;
    logic   conf;
    logic   en;
  } vq_entry_t;

endpackage

// File: rtl/vp_valq_mem.sv
// Entry storage for the validation queue: two write ports, two asynchronous read ports.
// No reset: occupancy is tracked entirely by the pointer logic in the parent.
module vp_valq_mem
  import vp_pkg::*;
#(
  parameter int unsigned P_DEPTH = 16,
  localparam int unsigned AW = $clog2(P_DEPTH)
) (
  input  logic          clk_i,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  vq_entry_t     wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  vq_entry_t     wdata1,
  input  logic [AW-1:0] raddr0,
  output vq_entry_t     rdata0,
  input  logic [AW-1:0] raddr1,
  output vq_entry_t     rdata1
);

  vq_entry_t mem_q [P_DEPTH];

  // Parent guarantees the two write addresses differ whenever both enables are set.
  always_ff @(posedge clk_i) begin
    if (we0) mem_q[waddr0] <= wdata0;
    if (we1) mem_q[waddr1] <= wdata1;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/vp_validation_queue.sv
// In-order validation queue pairing value predictions with writeback results.
// Optional statistics counters are enabled by defining VP_VALQ_STATS_EN.
module vp_validation_queue
  import vp_pkg::*;
#(
  parameter int unsigned P_DEPTH     = 16,
  parameter int unsigned P_CNT_WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0][31:1] pred_pc_e1_i,
  input  logic [1:0][31:0] pred_result_e1_i,
  input  logic [1:0]       pred_conf_e1_i,
  input  logic [1:0]       pred_valid_e1_i,
  input  logic [1:0]       pred_en_e1_i,
  input  logic [1:0][31:1] wb_pc_i,
  input  logic [1:0][31:0] wb_actual_i,
  input  logic [1:0]       wb_valid_i,
  input  logic             flush_i,
  output logic [1:0][31:1] fb_pc_o,
  output logic [1:0][31:0] fb_actual_o,
  output logic [1:0]       fb_mispredict_o,
  output logic [1:0]       fb_conf_o,
  output logic [1:0]       fb_used_o,
  output logic [1:0]       fb_valid_o,
  output logic             full_o,
  output logic             drop_o,
  output logic             resync_o
`ifdef VP_VALQ_STATS_EN
  ,
  output logic [P_CNT_WIDTH-1:0] stat_mispred_o,
  output logic [P_CNT_WIDTH-1:0] stat_drop_o
`endif
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned CW = AW + 1;

  if (P_DEPTH < 4 || (P_DEPTH & (P_DEPTH - 1)) != 0 || P_CNT_WIDTH < 2) begin : g_bad_param
    $error("vp_validation_queue: P_DEPTH must be a power of two >= 4, P_CNT_WIDTH >= 2");
  end

  logic [AW-1:0] head_q, tail_q, head_d, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;

  logic [1:0]    n_enq, n_acc, n_deq;
  logic [CW-1:0] free_cnt;
  logic          enq_ok;
  logic          pop0, pop1, hit0, hit1;
  logic          we0, we1;
  vq_entry_t     wdata0, wdata1, rdata0, rdata1;
  logic [AW-1:0] raddr1;

  // Enqueue: admission is judged against occupancy before this cycle's retire.
  assign n_enq    = {1'b0, pred_valid_e1_i[0]} + {1'b0, pred_valid_e1_i[1]};
  assign free_cnt = CW'(P_DEPTH) - count_q;
  assign enq_ok   = free_cnt >= CW'(n_enq);
  assign n_acc    = (enq_ok && !flush_i) ? n_enq : 2'd0;
  assign drop_o   = !flush_i && !enq_ok;

  assign we0    = n_acc != 2'd0;
  assign we1    = n_acc == 2'd2;
  assign wdata0 = pred_valid_e1_i[0]
                ? '{pc: pred_pc_e1_i[0], result: pred_result_e1_i[0],
                    conf: pred_conf_e1_i[0], en: pred_en_e1_i[0]}
                : '{pc: pred_pc_e1_i[1], result: pred_result_e1_i[1],
                    conf: pred_conf_e1_i[1], en: pred_en_e1_i[1]};
  assign wdata1 = '{pc: pred_pc_e1_i[1], result: pred_result_e1_i[1],
                    conf: pred_conf_e1_i[1], en: pred_en_e1_i[1]};

  // Retire: lane 1 looks past the head only when lane 0 actually consumed it.
  assign pop0   = wb_valid_i[0] && (count_q != '0);
  assign pop1   = wb_valid_i[1] && (count_q > CW'(pop0));
  assign raddr1 = head_q + AW'(pop0);
  assign hit0   = rdata0.pc == wb_pc_i[0];
  assign hit1   = rdata1.pc == wb_pc_i[1];
  assign n_deq  = {1'b0, pop0} + {1'b0, pop1};

  vp_valq_mem #(.P_DEPTH(P_DEPTH)) u_mem (
    .clk_i  (clk_i),
    .we0    (we0),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (tail_q + AW'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q),
    .rdata0 (rdata0),
    .raddr1 (raddr1),
    .rdata1 (rdata1)
  );

  always_comb begin
    head_d  = head_q + AW'(n_deq);
    tail_d  = tail_q + AW'(n_acc);
    count_d = count_q + CW'(n_acc) - CW'(n_deq);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (CW'(P_DEPTH) - count_d) < CW'(2);
    end
  end

  // Stage p1: registered feedback, one cycle after the writeback cycle.
  logic [1:0][31:1] fb_pc_p1;
  logic [1:0][31:0] fb_actual_p1;
  logic [1:0]       fb_mis_p1, fb_conf_p1, fb_used_p1, fb_valid_p1;
  logic             resync_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fb_pc_p1     <= '0;
      fb_actual_p1 <= '0;
      fb_mis_p1    <= '0;
      fb_conf_p1   <= '0;
      fb_used_p1   <= '0;
      fb_valid_p1  <= '0;
      resync_p1    <= 1'b0;
    end else begin
      fb_pc_p1     <= {rdata1.pc, rdata0.pc};
      fb_actual_p1 <= wb_actual_i;
      fb_conf_p1   <= {rdata1.conf, rdata0.conf};
      fb_used_p1   <= {rdata1.en, rdata0.en};
      fb_valid_p1  <= flush_i ? 2'b00 : {pop1 && hit1, pop0 && hit0};
      fb_mis_p1    <= flush_i ? 2'b00
                    : {pop1 && hit1 && (wb_actual_i[1] != rdata1.result),
                       pop0 && hit0 && (wb_actual_i[0] != rdata0.result)};
      resync_p1    <= !flush_i && ((pop0 && !hit0) || (pop1 && !hit1));
    end
  end

  assign fb_pc_o         = fb_pc_p1;
  assign fb_actual_o     = fb_actual_p1;
  assign fb_mispredict_o = fb_mis_p1;
  assign fb_conf_o       = fb_conf_p1;
  assign fb_used_o       = fb_used_p1;
  assign fb_valid_o      = fb_valid_p1;
  assign full_o          = full_q;
  assign resync_o        = resync_p1;

`ifdef VP_VALQ_STATS_EN
  function automatic logic [P_CNT_WIDTH-1:0] sat_add(input logic [P_CNT_WIDTH-1:0] a,
                                                     input logic [1:0] b);
    logic [P_CNT_WIDTH:0] s;
    s = {1'b0, a} + (P_CNT_WIDTH + 1)'(b);
    return s[P_CNT_WIDTH] ? '1 : s[P_CNT_WIDTH-1:0];
  endfunction

  logic [P_CNT_WIDTH-1:0] stat_mispred_q, stat_drop_q;
  logic [1:0]             n_mis;

  // Counts mispredict bits as they are presented on the feedback outputs.
  assign n_mis = {1'b0, fb_valid_p1[0] & fb_mis_p1[0]} + {1'b0, fb_valid_p1[1] & fb_mis_p1[1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_mispred_q <= '0;
      stat_drop_q    <= '0;
    end else begin
      stat_mispred_q <= sat_add(stat_mispred_q, n_mis);
      stat_drop_q    <= sat_add(stat_drop_q, {1'b0, drop_o});
    end
  end

  assign stat_mispred_o = stat_mispred_q;
  assign stat_drop_o    = stat_drop_q;
`endif

endmodule

// File: tb/tb_vp_validation_queue.sv
// Scoreboard bench for vp_validation_queue: a queue-based reference model predicts
// feedback, drops, resyncs and fullness; a negedge monitor compares against the DUT.
module tb_vp_validation_queue;
  import vp_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0][31:1] pred_pc;
  logic [1:0][31:0] pred_result;
  logic [1:0]       pred_conf, pred_valid, pred_en;
  logic [1:0][31:1] wb_pc;
  logic [1:0][31:0] wb_actual;
  logic [1:0]       wb_valid;
  logic             flush;
  logic [1:0][31:1] fb_pc;
  logic [1:0][31:0] fb_actual;
  logic [1:0]       fb_mispredict, fb_conf, fb_used, fb_valid;
  logic             full, drop, resync;

  vp_validation_queue #(.P_DEPTH(DEPTH), .P_CNT_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pred_pc_e1_i     (pred_pc),
    .pred_result_e1_i (pred_result),
    .pred_conf_e1_i   (pred_conf),
    .pred_valid_e1_i  (pred_valid),
    .pred_en_e1_i     (pred_en),
    .wb_pc_i          (wb_pc),
    .wb_actual_i      (wb_actual),
    .wb_valid_i       (wb_valid),
    .flush_i          (flush),
    .fb_pc_o          (fb_pc),
    .fb_actual_o      (fb_actual),
    .fb_mispredict_o  (fb_mispredict),
    .fb_conf_o        (fb_conf),
    .fb_used_o        (fb_used),
    .fb_valid_o       (fb_valid),
    .full_o           (full),
    .drop_o           (drop),
    .resync_o         (resync)
  );

  typedef struct {
    int     lane;
    pc_t    pc;
    value_t act;
    logic   mis;
    logic   conf;
    logic   used;
  } fb_t;

  typedef struct {
    logic [1:0] fbv;
    logic       resync;
    logic       full;
  } reg_t;

  localparam reg_t REG_ZERO = '{fbv: 2'b00, resync: 1'b0, full: 1'b0};

  vq_entry_t model_q[$];
  fb_t       fbq[$];
  reg_t      regq[$];
  logic      dropq[$];
  int        last_fb_pushed;
  int        n_checks = 0;
  int        n_pass = 0;
  bit        running = 1'b0;

  logic       s_rst, s_flush;
  logic [1:0] s_pv, s_pconf, s_pen, s_wv;
  pc_t        s_ppc[2], s_wpc[2];
  value_t     s_pres[2], s_wact[2];

  function automatic pc_t pc(input logic [31:0] a);
    return a[31:1];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle();
    s_pv = 2'b00; s_wv = 2'b00; s_flush = 1'b0;
    s_pconf = 2'b00; s_pen = 2'b00;
    for (int l = 0; l < 2; l++) begin
      s_ppc[l] = pc_t'($urandom); s_pres[l] = $urandom;
      s_wpc[l] = pc_t'($urandom); s_wact[l] = $urandom;
    end
  endtask

  task automatic set_enq(input int l, input pc_t p, input value_t v, input logic c, input logic e);
    s_pv[l] = 1'b1; s_ppc[l] = p; s_pres[l] = v; s_pconf[l] = c; s_pen[l] = e;
  endtask

  // Point a writeback lane at the idx-th oldest model entry (random PC if none).
  task automatic set_wb_match(input int l, input int idx, input value_t act);
    s_wv[l] = 1'b1;
    s_wact[l] = act;
    s_wpc[l] = (idx < model_q.size()) ? model_q[idx].pc : pc_t'($urandom);
  endtask

  task automatic step();
    reg_t      r;
    vq_entry_t e;
    int        cnt, nv, idx;
    bit        acc;
    @(posedge clk); #1;
    rst_n = s_rst; flush = s_flush;
    pred_valid = s_pv; pred_conf = s_pconf; pred_en = s_pen; wb_valid = s_wv;
    for (int l = 0; l < 2; l++) begin
      pred_pc[l] = s_ppc[l]; pred_result[l] = s_pres[l];
      wb_pc[l] = s_wpc[l]; wb_actual[l] = s_wact[l];
    end
    r = REG_ZERO;
    if (!s_rst) begin
      // Asynchronous reset wipes whatever the previous edge had just presented.
      repeat (last_fb_pushed) void'(fbq.pop_back());
      regq[regq.size()-1] = REG_ZERO;
      model_q.delete();
      dropq.push_back(1'b0);
      regq.push_back(REG_ZERO);
      last_fb_pushed = 0;
    end else if (s_flush) begin
      model_q.delete();
      dropq.push_back(1'b0);
      regq.push_back(REG_ZERO);
      last_fb_pushed = 0;
    end else begin
      cnt = model_q.size();
      nv  = int'(s_pv[0]) + int'(s_pv[1]);
      acc = (DEPTH - cnt) >= nv;
      dropq.push_back(!acc);
      idx = 0;
      last_fb_pushed = 0;
      for (int l = 0; l < 2; l++) begin
        if (s_wv[l] && idx < cnt) begin
          e = model_q[idx];
          idx++;
          if (e.pc == s_wpc[l]) begin
            fbq.push_back('{lane: l, pc: e.pc, act: s_wact[l], mis: (s_wact[l] != e.result),
                            conf: e.conf, used: e.en});
            r.fbv[l] = 1'b1;
            last_fb_pushed++;
          end else begin
            r.resync = 1'b1;
          end
        end
      end
      repeat (idx) void'(model_q.pop_front());
      if (acc)
        for (int l = 0; l < 2; l++)
          if (s_pv[l])
            model_q.push_back('{pc: s_ppc[l], result: s_pres[l], conf: s_pconf[l], en: s_pen[l]});
      r.full = (DEPTH - model_q.size()) < 2;
      regq.push_back(r);
    end
  endtask

  reg_t mon_r;
  fb_t  mon_f;
  logic mon_d;

  always @(negedge clk) begin
    if (running) begin
      if (dropq.size() == 0 || regq.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: drop %0d reg %0d entries, required >0", dropq.size(), regq.size());
      end else begin
        mon_d = dropq.pop_front();
        check("drop_o", 64'(drop), 64'(mon_d));
        mon_r = regq.pop_front();
        check("fb_valid_o", 64'(fb_valid), 64'(mon_r.fbv));
        check("resync_o", 64'(resync), 64'(mon_r.resync));
        check("full_o", 64'(full), 64'(mon_r.full));
        for (int l = 0; l < 2; l++) begin
          if (fb_valid[l]) begin
            if (fbq.size() == 0) begin
              n_checks++;
              $display("FAIL fb_unexpected: lane %0d valid with empty scoreboard", l);
            end else begin
              mon_f = fbq.pop_front();
              check("fb_lane", 64'(l), 64'(mon_f.lane));
              check("fb_pc_o", 64'(fb_pc[l]), 64'(mon_f.pc));
              check("fb_actual_o", 64'(fb_actual[l]), 64'(mon_f.act));
              check("fb_mispredict_o", 64'(fb_mispredict[l]), 64'(mon_f.mis));
              check("fb_conf_o", 64'(fb_conf[l]), 64'(mon_f.conf));
              check("fb_used_o", 64'(fb_used[l]), 64'(mon_f.used));
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    pred_pc = '0; pred_result = '0; pred_conf = '0; pred_valid = '0; pred_en = '0;
    wb_pc = '0; wb_actual = '0; wb_valid = '0;
    s_rst = 1'b1;
    idle();
    last_fb_pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fb_valid", 64'(fb_valid), 64'(0));
    check("reset_full", 64'(full), 64'(0));
    check("reset_resync", 64'(resync), 64'(0));
    check("reset_drop", 64'(drop), 64'(0));
    @(negedge clk); #1;
    regq.push_back(REG_ZERO);
    running = 1'b1;

    // Basic pair: one correct, one mispredicted.
    idle(); set_enq(0, pc(32'h100), 32'd5, 1'b1, 1'b1); set_enq(1, pc(32'h102), 32'd7, 1'b0, 1'b1); step();
    idle(); s_wv = 2'b11;
    s_wpc[0] = pc(32'h100); s_wact[0] = 32'd5; s_wpc[1] = pc(32'h102); s_wact[1] = 32'd9; step();
    idle(); step();
    check("pair_fb_valid", 64'(fb_valid), 64'(2'b11));
    check("pair_fb_mispredict", 64'(fb_mispredict), 64'(2'b10));

    // Fill to 15, pair dropped, single accepted, then a further single dropped.
    for (int i = 0; i < 7; i++) begin
      idle();
      set_enq(0, pc(32'h1000 + 8*i), i, 1'b1, 1'b0);
      set_enq(1, pc(32'h1004 + 8*i), i + 1, 1'b0, 1'b1);
      step();
    end
    idle(); set_enq(1, pc(32'h1100), 32'd3, 1'b1, 1'b1); step();
    idle(); set_enq(0, pc(32'h1200), 32'd1, 1'b0, 1'b0); set_enq(1, pc(32'h1204), 32'd2, 1'b0, 1'b0); step();
    #1 check("drop_at_15", 64'(drop), 64'(1));
    idle(); set_enq(0, pc(32'h1300), 32'd4, 1'b1, 1'b0); step();
    idle(); set_enq(1, pc(32'h1400), 32'd4, 1'b1, 1'b0); step();
    #1 check("drop_at_16", 64'(drop), 64'(1));
    for (int i = 0; i < 8; i++) begin
      idle(); set_wb_match(0, 0, 32'd2); set_wb_match(1, 1, 32'd4); step();
    end

    // PC mismatch at the head.
    idle(); set_enq(0, pc(32'h200), 32'd11, 1'b1, 1'b1); step();
    idle(); s_wv = 2'b01; s_wpc[0] = pc(32'h204); s_wact[0] = 32'd11; step();
    idle(); step();
    check("mismatch_resync", 64'(resync), 64'(1));
    check("mismatch_fb_valid0", 64'(fb_valid[0]), 64'(0));

    // Streaming through the ring so pointers wrap.
    for (int i = 0; i < 20; i++) begin
      idle(); set_enq(0, pc(32'h3000 + 2*i), i, i[0], i[1]); set_wb_match(0, 0, i); step();
    end
    idle(); set_wb_match(0, 0, 32'd19); step();

    // Flush with five entries plus concurrent enqueue and writeback.
    idle(); set_enq(0, pc(32'h4000), 1, 1, 1); set_enq(1, pc(32'h4002), 2, 1, 1); step();
    idle(); set_enq(0, pc(32'h4004), 3, 1, 1); set_enq(1, pc(32'h4006), 4, 1, 1); step();
    idle(); set_enq(0, pc(32'h4008), 5, 1, 1); step();
    idle(); set_enq(0, pc(32'h400a), 6, 1, 1); set_enq(1, pc(32'h400c), 7, 1, 1);
    set_wb_match(0, 0, 1); set_wb_match(1, 1, 2); s_flush = 1'b1; step();
    #1 check("flush_drop", 64'(drop), 64'(0));
    idle(); s_wv = 2'b11; s_wpc[0] = pc(32'h4000); s_wpc[1] = pc(32'h4002); step();
    idle(); step();

    // Asynchronous reset with eight entries and feedback in flight.
    for (int i = 0; i < 4; i++) begin
      idle(); set_enq(0, pc(32'h5000 + 4*i), 7, 1, 1); set_enq(1, pc(32'h5002 + 4*i), 8, 1, 1); step();
    end
    idle(); set_wb_match(0, 0, 32'd7); set_wb_match(1, 1, 32'd9); step();
    idle(); s_rst = 1'b0; step();
    #1;
    check("rst_fb_valid", 64'(fb_valid), 64'(0));
    check("rst_fb_pc", 64'(fb_pc), 64'(0));
    check("rst_fb_actual", 64'(fb_actual), 64'(0));
    check("rst_fb_flags", 64'({fb_mispredict, fb_conf, fb_used}), 64'(0));
    check("rst_full_resync", 64'({full, resync}), 64'(0));
    idle(); step();
    idle(); s_rst = 1'b1; step();
    idle(); s_wv = 2'b11; s_wpc[0] = pc(32'h5008); s_wpc[1] = pc(32'h500a); step();
    idle(); s_wv = 2'b01; s_wpc[0] = pc(32'h500c); step();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      idle();
      s_flush = ($urandom_range(0, 49) == 0);
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(0, 1) == 1)
          set_enq(l, pc_t'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      end
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_wb_match(l, (l == 1 && s_wv[0]) ? 1 : 0, $urandom_range(0, 3));
          if ($urandom_range(0, 5) == 0) s_wpc[l] = pc_t'($urandom);
        end
      end
      step();
    end

    repeat (3) begin idle(); step(); end
    @(negedge clk); #1;
    running = 1'b0;
    check("scoreboard_drained", 64'(fbq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
